spy_bus_ctrl: RTL and testbench
===============================

Name: spy_bus_ctrl

Overview:
- Sequences all accesses to the spy examine/deposit bus and arbitrates it between two requesters: port 0 (serial debug link) and port 1 (host bus bridge).
- Decodes a 5-bit spy register address into the one-hot spy select strobes.
- Drives dbread/dbwrite with setup, settle and hold timing.
- Captures read data from the spy mux output and returns it with a one-cycle acknowledge.

Parameters:
- SETTLE, 2: cycles dbread/dbwrite stay asserted; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- r0_req  in  1  port 0 request, level, held until r0_ack
- r0_we  in  1  port 0 write (1) / read (0)
- r0_addr  in  5  port 0 spy register address
- r0_wdata  in  16  port 0 write data
- r0_ack  out  1  port 0 completion pulse, 1 cycle
- r1_req  in  1  port 1 request
- r1_we  in  1  port 1 write / read
- r1_addr  in  5  port 1 address
- r1_wdata  in  16  port 1 write data
- r1_ack  out  1  port 1 completion pulse
- rdata  out  16  captured read data, valid with ack
- spy_in  in  16  spy mux output (16'hFFFF when idle)
- spy_sel  out  24  one-hot register select, bit n = address n
- spy_wdata  out  16  deposit data to spy bus
- dbread  out  1  spy read strobe
- dbwrite  out  1  spy write strobe
- busy  out  1  high in any state other than IDLE

Behaviour:
- Address map, bit n of spy_sel:
  - 0 irl, 1 irm, 2 irh, 3 scratch, 4 opc, 5 pc
  - 6 obl_, 7 obh_, 8 obl, 9 obh
  - 10 flag1, 11 flag2, 12 ml, 13 mh, 14 al, 15 ah
  - 16 stl, 17 sth, 18 mdl, 19 mdh, 20 vmal, 21 vmah
  - 22 disk, 23 bd
- Addresses 24..31: spy_sel stays all-zero through the whole transaction; timing is unchanged; read returns 16'hFFFF; write has no effect; ack is still given.
- Reset values: state IDLE, spy_sel 0, spy_wdata 0, dbread 0, dbwrite 0, r0_ack 0, r1_ack 0, rdata 16'hFFFF, busy 0, round-robin pointer "last granted = 1", so port 0 wins the first tie.
- FSM: IDLE -> SETUP -> ACCESS -> HOLD -> ACK -> IDLE.
- IDLE: sample r0_req/r1_req.
  - One requester: grant it.
  - Both requesting: grant the port not last granted.
  - On grant, latch that port's we/addr/wdata and the grant id, update the pointer, go to SETUP.
- SETUP (1 cycle): spy_sel decoded, spy_wdata driven; dbread and dbwrite both 0.
- ACCESS (SETTLE cycles, 4-bit down-counter): dbread=1 for reads, dbwrite=1 for writes; spy_sel and spy_wdata held.
  - Reads: capture spy_in on the last ACCESS cycle into an internal register.
- HOLD (1 cycle): strobes 0; spy_sel and spy_wdata held.
- ACK (1 cycle):
  - Granted port's ack=1.
  - spy_sel cleared.
  - For reads, rdata updated with the captured value at entry to ACK. rdata holds until the next read ack; writes leave rdata unchanged.
- Latency: r_req first high at edge k (sampled in IDLE) -> ack high in cycle k+SETTLE+3. With SETTLE=2 this is 5 cycles.
  - Back-to-back: after ACK, IDLE takes 1 cycle before the next grant, so minimum period is SETTLE+4 cycles.
- Requests are sampled only in IDLE. A requester that drops req mid-transaction does not abort it; the bus sequence completes and ack still pulses.
- A request still high in the cycle after its own ack is treated as a new request. Requesters must drop req on ack.
- dbread and dbwrite are never high simultaneously. spy_sel never changes while either strobe is high.
- Reset mid-transaction: all outputs return to reset values on the next edge; no ack is issued; the pointer resets.

Test Plan:
- Single read: SETTLE=2, spy_in=16'h1234, r0 reads addr 5 at edge 0 ->
  - spy_sel=24'h000020 from cycle 1;
  - dbread high cycles 2-3;
  - r0_ack and rdata=16'h1234 in cycle 5.
- Single write: r1 writes 16'hBEEF to addr 3 ->
  - spy_wdata=16'hBEEF and spy_sel bit 3 set from SETUP through HOLD;
  - dbwrite high exactly SETTLE cycles;
  - r1_ack only; rdata unchanged.
- Contention: r0 and r1 both hold req from reset ->
  - grants alternate r0, r1, r0, r1;
  - ack spacing SETTLE+4 cycles;
  - no ack ever on the wrong port.
- Unmapped address: r0 reads addr 27 with spy_in=16'hFFFF ->
  - spy_sel stays 0 throughout;
  - dbread pulses normally;
  - rdata=16'hFFFF with ack in cycle SETTLE+3.
- Abort by reset: assert reset during ACCESS ->
  - next cycle dbread=0, spy_sel=0, busy=0, no ack;
  - first request after reset (both ports) goes to r0.
- Dropped request and SETTLE sweep: r1_req drops during ACCESS -> r1_ack still pulses. Repeat the single read with SETTLE=1 and SETTLE=15 -> ack in cycles 4 and 18.

Source files
------------

// File: rtl/spy_bus_ctrl_if.sv
// Requester and spy-bus signal bundle for spy_bus_ctrl.
// The slave modport is the controller; master is the requester/spy side.
`timescale 1ns/1ps
interface spy_bus_ctrl_if;
  logic        r0_req;
  logic        r0_we;
  logic [4:0]  r0_addr;
  logic [15:0] r0_wdata;
  logic        r0_ack;
  logic        r1_req;
  logic        r1_we;
  logic [4:0]  r1_addr;
  logic [15:0] r1_wdata;
  logic        r1_ack;
  logic [15:0] rdata;
  logic [15:0] spy_in;
  logic [23:0] spy_sel;
  logic [15:0] spy_wdata;
  logic        dbread;
  logic        dbwrite;
  logic        busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  spy_in,
    output r0_ack, r1_ack, rdata, spy_sel, spy_wdata, dbread, dbwrite, busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output spy_in,
    input  r0_ack, r1_ack, rdata, spy_sel, spy_wdata, dbread, dbwrite, busy
  );
endinterface

// File: rtl/spy_bus_ctrl.sv
// Spy examine/deposit bus sequencer with round-robin arbitration between
// the serial debug link (port 0) and the host bus bridge (port 1).
//
// state    | meaning
// S_IDLE   | sample requests, grant and latch the winning port
// S_SETUP  | select decoded, deposit data driven, strobes low
// S_ACCESS | dbread/dbwrite high for SETTLE cycles, read data captured on last
// S_HOLD   | strobes low, select and data held
// S_ACK    | one-cycle ack to granted port, select cleared
`timescale 1ns/1ps
module spy_bus_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk,
  input  logic          reset,
  spy_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_ACK
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t      r_state;
  logic        r_last;
  logic        r_gnt;
  logic        r_we;
  logic        r_unmap;
  logic [3:0]  r_cnt;
  logic [15:0] r_cap;
  logic [23:0] r_sel;
  logic [15:0] r_wdata;
  logic        r_dbread;
  logic        r_dbwrite;
  logic        r_ack0;
  logic        r_ack1;
  logic [15:0] r_rdata;
  logic        r_busy;

  logic        w_any_req;
  logic        w_pick1;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [15:0] w_wdata;

  function automatic logic [23:0] f_decode(input logic [4:0] addr);
    logic [23:0] v;
    v = '0;
    if (addr < 5'd24) v[addr] = 1'b1;
    return v;
  endfunction

  // On a tie, port 1 wins only if port 0 was granted last.
  assign w_any_req = bus.r0_req | bus.r1_req;
  assign w_pick1   = bus.r1_req & (~bus.r0_req | ~r_last);
  assign w_we      = w_pick1 ? bus.r1_we    : bus.r0_we;
  assign w_addr    = w_pick1 ? bus.r1_addr  : bus.r0_addr;
  assign w_wdata   = w_pick1 ? bus.r1_wdata : bus.r0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_we      <= 1'b0;
      r_unmap   <= 1'b0;
      r_cnt     <= 4'd0;
      r_cap     <= 16'hFFFF;
      r_sel     <= '0;
      r_wdata   <= '0;
      r_dbread  <= 1'b0;
      r_dbwrite <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rdata   <= 16'hFFFF;
      r_busy    <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_pick1;
            r_last  <= w_pick1;
            r_we    <= w_we;
            r_unmap <= (w_addr >= 5'd24);
            r_sel   <= f_decode(w_addr);
            r_wdata <= w_wdata;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt     <= SETTLE_M1;
          r_dbread  <= ~r_we;
          r_dbwrite <= r_we;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_dbread  <= 1'b0;
            r_dbwrite <= 1'b0;
            if (!r_we) r_cap <= r_unmap ? 16'hFFFF : bus.spy_in;
            r_state   <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          r_sel   <= '0;
          r_ack0  <= ~r_gnt;
          r_ack1  <= r_gnt;
          if (!r_we) r_rdata <= r_cap;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.r0_ack    = r_ack0;
  assign bus.r1_ack    = r_ack1;
  assign bus.rdata     = r_rdata;
  assign bus.spy_sel   = r_sel;
  assign bus.spy_wdata = r_wdata;
  assign bus.dbread    = r_dbread;
  assign bus.dbwrite   = r_dbwrite;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_spy_bus_ctrl.sv
// Scoreboard bench for spy_bus_ctrl: requester drivers push expectations,
// a negedge monitor pops them on every ack; a spy register array sits on the bus.
`timescale 1ns/1ps
module tb_spy_bus_ctrl;
  localparam int S = 2;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    bit          hold;
    bit          solo;
    bit          drop;
  } txn_t;

  typedef struct {
    logic        we;
    logic [15:0] rdata;
    int          t0;
    bit          solo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spy_bus_ctrl_if bus ();
  spy_bus_ctrl_if bus1 ();
  spy_bus_ctrl_if bus15 ();

  spy_bus_ctrl #(.SETTLE(S))  dut   (.clk(clk), .reset(reset), .bus(bus));
  spy_bus_ctrl #(.SETTLE(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));
  spy_bus_ctrl #(.SETTLE(15)) dut15 (.clk(clk), .reset(reset), .bus(bus15));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit prev_strobe;
  logic [23:0] prev_sel;
  logic [15:0] model_rdata = 16'hFFFF;
  logic [15:0] mem [24];
  logic [15:0] shadow [24];
  txn_t stim_q0[$], stim_q1[$];
  exp_t exp_q0[$], exp_q1[$];
  int ack_port[$], ack_cyc[$];

  function automatic logic [15:0] init_val(int i);
    return (i == 5) ? 16'h1234 : 16'(16'h1000 + i * 273);
  endfunction

  // Spy register array seen through the spy mux; idle mux reads all-ones.
  always_comb begin
    bus.spy_in = 16'hFFFF;
    if (bus.dbread)
      for (int i = 0; i < 24; i++)
        if (bus.spy_sel == (24'd1 << i)) bus.spy_in = mem[i];
  end
  assign bus1.spy_in  = 16'h1234;
  assign bus15.spy_in = 16'h1234;

  initial begin
    for (int i = 0; i < 24; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bus.dbwrite)
        for (int i = 0; i < 24; i++)
          if (bus.spy_sel == (24'd1 << i)) mem[i] = bus.spy_wdata;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [15:0] model_issue(txn_t t);
    if (t.addr >= 5'd24) return 16'hFFFF;
    if (t.we) begin
      shadow[t.addr] = t.wdata;
      return 16'h0000;
    end
    return shadow[t.addr];
  endfunction

  task automatic set_req(int p, logic req, logic we, logic [4:0] a, logic [15:0] d);
    if (p == 0) begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  function automatic logic get_ack(int p);
    return (p == 0) ? bus.r0_ack : bus.r1_ack;
  endfunction

  task automatic push_exp(int p, txn_t t);
    exp_t e;
    e.we = t.we;
    e.rdata = model_issue(t);
    e.t0 = cyc;
    e.solo = t.solo;
    if (p == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic handle_ack(int p);
    exp_t e;
    int sz;
    sz = (p == 0) ? exp_q0.size() : exp_q1.size();
    n_checks++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL unexpected_ack: port %0d acked with no pending request, required no ack (cycle %0d)", p, cyc);
      return;
    end
    if (p == 0) e = exp_q0.pop_front();
    else e = exp_q1.pop_front();
    if (!e.we) model_rdata = e.rdata;
    chk("rdata_at_ack", bus.rdata, model_rdata);
    if (e.solo) chk("ack_latency", cyc - e.t0, S + 3);
    ack_port.push_back(p);
    ack_cyc.push_back(cyc);
  endtask

  initial begin
    prev_strobe = 0;
    prev_sel = '0;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        prev_strobe = 0;
      end else begin
        if (bus.dbread || bus.dbwrite) begin
          chk("strobe_exclusive", bus.dbread & bus.dbwrite, 0);
          chk("busy_during_strobe", bus.busy, 1);
          if (prev_strobe) chk("sel_stable_under_strobe", bus.spy_sel, prev_sel);
        end
        if (bus.spy_sel != 24'd0) chk("sel_onehot", $onehot(bus.spy_sel), 1);
        if (bus.r0_ack || bus.r1_ack) chk("single_ack", bus.r0_ack & bus.r1_ack, 0);
        if (bus.r0_ack) handle_ack(0);
        if (bus.r1_ack) handle_ack(1);
        prev_strobe = bus.dbread | bus.dbwrite;
        prev_sel = bus.spy_sel;
      end
    end
  end

  task automatic drive_port(int p);
    txn_t t;
    bit prev_hold;
    bit hold;
    bit got;
    prev_hold = 0;
    while (((p == 0) ? stim_q0.size() : stim_q1.size()) > 0) begin
      if (p == 0) t = stim_q0.pop_front();
      else t = stim_q1.pop_front();
      hold = t.hold && (((p == 0) ? stim_q0.size() : stim_q1.size()) > 0);
      if (!prev_hold) @(negedge clk);
      push_exp(p, t);
      set_req(p, 1'b1, t.we, t.addr, t.wdata);
      got = 0;
      for (int n = 0; n < 200 && !got; n++) begin
        @(negedge clk);
        if (t.drop && n == 1) set_req(p, 1'b0, t.we, t.addr, t.wdata);
        if (get_ack(p)) got = 1;
      end
      chk("ack_seen_within_bound", got, 1);
      if (!got) begin
        set_req(p, 1'b0, t.we, t.addr, t.wdata);
        return;
      end
      if (!hold) set_req(p, 1'b0, t.we, t.addr, t.wdata);
      prev_hold = hold;
    end
  endtask

  // Solo transaction with a cycle-by-cycle check of the bus waveform.
  task automatic run_profile(int p, logic we, logic [4:0] a, logic [15:0] d);
    txn_t t;
    logic [23:0] exp_sel;
    t.we = we; t.addr = a; t.wdata = d; t.hold = 0; t.solo = 1; t.drop = 0;
    @(negedge clk);
    push_exp(p, t);
    set_req(p, 1'b1, we, a, d);
    for (int n = 1; n <= S + 3; n++) begin
      @(negedge clk);
      exp_sel = (n <= S + 2 && a < 5'd24) ? (24'd1 << a) : 24'd0;
      chk("prof_spy_sel", bus.spy_sel, exp_sel);
      chk("prof_dbread", bus.dbread, (!we && n >= 2 && n <= S + 1));
      chk("prof_dbwrite", bus.dbwrite, (we && n >= 2 && n <= S + 1));
      if (we && n <= S + 2) chk("prof_spy_wdata", bus.spy_wdata, d);
      chk("prof_ack_own", get_ack(p), (n == S + 3));
      chk("prof_ack_other", get_ack(1 - p), 0);
      chk("prof_busy", bus.busy, 1);
    end
    set_req(p, 1'b0, we, a, d);
  endtask

  task automatic sweep_s1();
    int t0;
    bit got;
    @(negedge clk);
    bus1.r0_req = 1; bus1.r0_we = 0; bus1.r0_addr = 5'd5;
    t0 = cyc;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus1.r0_ack) got = 1;
    end
    bus1.r0_req = 0;
    chk("settle1_ack_seen", got, 1);
    chk("settle1_latency", cyc - t0, 4);
    chk("settle1_rdata", bus1.rdata, 16'h1234);
  endtask

  task automatic sweep_s15();
    int t0;
    bit got;
    @(negedge clk);
    bus15.r0_req = 1; bus15.r0_we = 0; bus15.r0_addr = 5'd5;
    t0 = cyc;
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (bus15.r0_ack) got = 1;
    end
    bus15.r0_req = 0;
    chk("settle15_ack_seen", got, 1);
    chk("settle15_latency", cyc - t0, 18);
    chk("settle15_rdata", bus15.rdata, 16'h1234);
  endtask

  function automatic txn_t rand_txn(int p);
    txn_t t;
    int r;
    r = $urandom_range(0, 15);
    if (p == 0) t.addr = (r < 12) ? 5'(r) : 5'(24 + r - 12);
    else t.addr = (r < 12) ? 5'(12 + r) : 5'(28 + r - 12);
    t.we = 1'($urandom_range(0, 1));
    t.wdata = 16'($urandom);
    t.hold = 1'($urandom_range(0, 1));
    t.solo = 0;
    t.drop = 0;
    return t;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    txn_t t;
    for (int i = 0; i < 24; i++) shadow[i] = init_val(i);
    reset = 1;
    set_req(0, 0, 0, 5'd0, 16'd0);
    set_req(1, 0, 0, 5'd0, 16'd0);
    bus1.r0_req = 0; bus1.r0_we = 0; bus1.r0_addr = 0; bus1.r0_wdata = 0;
    bus1.r1_req = 0; bus1.r1_we = 0; bus1.r1_addr = 0; bus1.r1_wdata = 0;
    bus15.r0_req = 0; bus15.r0_we = 0; bus15.r0_addr = 0; bus15.r0_wdata = 0;
    bus15.r1_req = 0; bus15.r1_we = 0; bus15.r1_addr = 0; bus15.r1_wdata = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset_spy_sel", bus.spy_sel, 0);
    chk("reset_spy_wdata", bus.spy_wdata, 0);
    chk("reset_dbread", bus.dbread, 0);
    chk("reset_dbwrite", bus.dbwrite, 0);
    chk("reset_r0_ack", bus.r0_ack, 0);
    chk("reset_r1_ack", bus.r1_ack, 0);
    chk("reset_rdata", bus.rdata, 16'hFFFF);
    chk("reset_busy", bus.busy, 0);
    mon_en = 1;

    run_profile(0, 1'b0, 5'd5, 16'h0000);
    chk("single_read_rdata", bus.rdata, 16'h1234);
    run_profile(1, 1'b1, 5'd3, 16'hBEEF);
    run_profile(0, 1'b0, 5'd3, 16'h0000);
    run_profile(0, 1'b0, 5'd27, 16'h0000);
    run_profile(1, 1'b1, 5'd30, 16'h5A5A);

    t.we = 0; t.addr = 5'd14; t.wdata = 0; t.hold = 0; t.solo = 1; t.drop = 1;
    stim_q1.push_back(t);
    drive_port(1);

    fork
      sweep_s1();
      sweep_s15();
    join

    // Abort during ACCESS; port 0 was granted last, so the pointer reset is visible.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 5'd2, 16'd0);
    for (int n = 0; n < 20 && !bus.dbread; n++) @(negedge clk);
    chk("abort_reached_access", bus.dbread, 1);
    reset = 1;
    set_req(0, 1'b0, 1'b0, 5'd2, 16'd0);
    @(negedge clk);
    chk("abort_dbread", bus.dbread, 0);
    chk("abort_spy_sel", bus.spy_sel, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_r0_ack", bus.r0_ack, 0);
    chk("abort_rdata", bus.rdata, 16'hFFFF);
    model_rdata = 16'hFFFF;
    reset = 0;
    @(negedge clk);
    chk("abort_no_late_ack", bus.r0_ack | bus.r1_ack, 0);

    ack_port.delete();
    ack_cyc.delete();
    for (int i = 0; i < 2; i++) begin
      t.we = 0; t.addr = 5'(1 + i); t.wdata = 0; t.hold = 1; t.solo = 0; t.drop = 0;
      stim_q0.push_back(t);
      t.we = 1; t.addr = 5'(13 + i); t.wdata = 16'(16'hC000 + i);
      stim_q1.push_back(t);
    end
    fork
      drive_port(0);
      drive_port(1);
    join
    chk("contention_ack_count", ack_port.size(), 4);
    for (int i = 0; i < ack_port.size() && i < 4; i++) begin
      chk("contention_port_order", ack_port[i], i % 2);
      if (i > 0) chk("contention_spacing", ack_cyc[i] - ack_cyc[i-1], S + 4);
    end

    for (int i = 0; i < 30; i++) begin
      stim_q0.push_back(rand_txn(0));
      stim_q1.push_back(rand_txn(1));
    end
    fork
      drive_port(0);
      drive_port(1);
    join
    for (int i = 0; i < 24; i++) begin
      t.we = 0; t.addr = 5'(i); t.wdata = 0; t.hold = 0; t.solo = 1; t.drop = 0;
      if (i < 12) stim_q0.push_back(t);
      else stim_q1.push_back(t);
    end
    drive_port(0);
    drive_port(1);
    repeat (10) @(negedge clk);
    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);
    chk("final_idle_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
